// File: rtl/wave_sweep_ctrl.sv
// wave_sweep_ctrl: sequencer that time-shares one combinational wave_unit
// across a 1-D array of N_CELLS cells stored as {u, du} words in an
// external single-port RAM with one-cycle read latency.
// A sliding window of registers holds the old neighbour values, so every
// cell in a sweep is computed from pre-update data.
// Optional feature macro: WAVE_SWEEP_ABORT_EN adds the abort/aborted ports.
module wave_sweep_ctrl #(
    parameter int N_CELLS = 64,
    parameter int AW      = 6,
    parameter int DW      = 16,
    parameter int SW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [SW-1:0] n_steps,
`ifdef WAVE_SWEEP_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] step_count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata_u,
    output logic [DW-1:0] mem_wdata_du,
    input  logic [DW-1:0] mem_rdata_u,
    input  logic [DW-1:0] mem_rdata_du,
    output logic [DW-1:0] wu_u,
    output logic [DW-1:0] wu_du,
    output logic [DW-1:0] wu_uL,
    output logic [DW-1:0] wu_uR,
    input  logic [DW-1:0] wu_u_new,
    input  logic [DW-1:0] wu_du_new
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRIME_RD  = 3'd1;
    localparam logic [2:0] S_PRIME_CAP = 3'd2;
    localparam logic [2:0] S_RD        = 3'd3;
    localparam logic [2:0] S_CAP       = 3'd4;
    localparam logic [2:0] S_WR        = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(N_CELLS - 1);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [SW-1:0] steps_total;
    logic [DW-1:0] w_l;
    logic [DW-1:0] w_u;
    logic [DW-1:0] w_du;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_rdu;
    logic          is_last;
    logic          abort_now;
    logic          sweep_final;

`ifdef WAVE_SWEEP_ABORT_EN
    logic abort_pend;
    // An abort seen in the current busy cycle takes effect at this very WR too
    assign abort_now = abort_pend | (busy & abort);
`else
    assign abort_now = 1'b0;
`endif

    assign is_last     = ({1'b0, idx} == LAST_IDX);
    assign sweep_final = ((step_count + SW'(1)) == steps_total);

    assign wu_u  = w_u;
    assign wu_du = w_du;
    assign wu_uL = w_l;
    assign wu_uR = w_r;

    // Main sequencer: state, cell index, step counter and neighbour window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            steps_total <= '0;
            step_count  <= '0;
            w_l         <= '0;
            w_u         <= '0;
            w_du        <= '0;
            w_r         <= '0;
            w_rdu       <= '0;
`ifdef WAVE_SWEEP_ABORT_EN
            abort_pend  <= 1'b0;
            aborted     <= 1'b0;
`endif
        end else begin
`ifdef WAVE_SWEEP_ABORT_EN
            if (busy && abort) begin
                abort_pend <= 1'b1;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        step_count  <= '0;
                        steps_total <= n_steps;
`ifdef WAVE_SWEEP_ABORT_EN
                        abort_pend  <= 1'b0;
                        aborted     <= 1'b0;
`endif
                        if (n_steps != '0) begin
                            state <= S_PRIME_RD;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_PRIME_RD: begin
                    w_l   <= '0;
                    idx   <= '0;
                    state <= S_PRIME_CAP;
                end
                S_PRIME_CAP: begin
                    w_u   <= mem_rdata_u;
                    w_du  <= mem_rdata_du;
                    state <= S_RD;
                end
                S_RD: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    if (is_last) begin
                        w_r   <= '0;
                        w_rdu <= '0;
                    end else begin
                        w_r   <= mem_rdata_u;
                        w_rdu <= mem_rdata_du;
                    end
                    state <= S_WR;
                end
                S_WR: begin
                    w_l  <= w_u;
                    w_u  <= w_r;
                    w_du <= w_rdu;
                    if (!is_last) begin
                        idx   <= idx + AW'(1);
                        state <= abort_now ? S_DONE : S_RD;
                    end else begin
                        step_count <= step_count + SW'(1);
                        state      <= (abort_now || sweep_final) ? S_DONE : S_PRIME_RD;
                    end
`ifdef WAVE_SWEEP_ABORT_EN
                    if (abort_now) begin
                        aborted <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM strobes, address and write data decoded from the current state
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        mem_addr     = '0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wdata_u  = '0;
        mem_wdata_du = '0;
        case (state)
            S_PRIME_RD: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
            end
            S_PRIME_CAP: begin
                busy = 1'b1;
            end
            S_RD: begin
                busy = 1'b1;
                if (is_last) begin
                    mem_addr = idx;
                end else begin
                    mem_addr  = idx + AW'(1);
                    mem_rd_en = 1'b1;
                end
            end
            S_CAP: begin
                busy = 1'b1;
            end
            S_WR: begin
                busy         = 1'b1;
                mem_addr     = idx;
                mem_wr_en    = 1'b1;
                mem_wdata_u  = wu_u_new;
                mem_wdata_du = wu_du_new;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// tb_wave_sweep_ctrl: self-checking bench for wave_sweep_ctrl with N_CELLS=4,
// a behavioural single-port RAM and a wave_unit stub (u+1, uL+uR).
// Expected RAM contents come from an array-level model of the sweep rule.
module tb_wave_sweep_ctrl;

    localparam int N      = 4;
    localparam int AW     = 2;
    localparam int DW     = 16;
    localparam int SW     = 16;
    localparam int SWEEP  = 2 + 3 * N;
    localparam int BUDGET = 2000;

    typedef struct packed {
        logic [15:0] n;
        logic [63:0] u_init;
        logic [63:0] du_init;
        logic [31:0] exp_lat;
        logic [15:0] exp_sc;
        logic [63:0] exp_u;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [SW-1:0] n_steps;
    logic          busy;
    logic          done;
    logic [SW-1:0] step_count;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata_u;
    logic [DW-1:0] mem_wdata_du;
    logic [DW-1:0] mem_rdata_u;
    logic [DW-1:0] mem_rdata_du;
    logic [DW-1:0] wu_u;
    logic [DW-1:0] wu_du;
    logic [DW-1:0] wu_uL;
    logic [DW-1:0] wu_uR;
    logic [DW-1:0] wu_u_new;
    logic [DW-1:0] wu_du_new;
`ifdef WAVE_SWEEP_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    logic [DW-1:0] ram_u [N];
    logic [DW-1:0] ram_du[N];
    logic [DW-1:0] load_u [N];
    logic [DW-1:0] load_du[N];
    logic          load_en;
    logic [DW-1:0] exp_u [N];
    logic [DW-1:0] exp_du[N];

    vec_t vecs[4];
    int   checks = 0;
    int   errors = 0;

    wave_sweep_ctrl #(.N_CELLS(N), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_steps      (n_steps),
`ifdef WAVE_SWEEP_ABORT_EN
        .abort        (abort),
        .aborted      (aborted),
`endif
        .busy         (busy),
        .done         (done),
        .step_count   (step_count),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata_u  (mem_wdata_u),
        .mem_wdata_du (mem_wdata_du),
        .mem_rdata_u  (mem_rdata_u),
        .mem_rdata_du (mem_rdata_du),
        .wu_u         (wu_u),
        .wu_du        (wu_du),
        .wu_uL        (wu_uL),
        .wu_uR        (wu_uR),
        .wu_u_new     (wu_u_new),
        .wu_du_new    (wu_du_new)
    );

    always #5 clk = ~clk;

    assign wu_u_new  = wu_u + 16'd1;
    assign wu_du_new = wu_uL + wu_uR;

    // Single-port RAM: one-cycle read latency, bench-side bulk load port
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < N; i++) begin
                ram_u[i]  <= load_u[i];
                ram_du[i] <= load_du[i];
            end
        end else if (mem_wr_en) begin
            ram_u[mem_addr]  <= mem_wdata_u;
            ram_du[mem_addr] <= mem_wdata_du;
        end
        if (mem_rd_en) begin
            mem_rdata_u  <= ram_u[mem_addr];
            mem_rdata_du <= ram_du[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic loadRam(input logic [63:0] u, input logic [63:0] du);
        for (int i = 0; i < N; i++) begin
            load_u[i]  = u[16*i +: 16];
            load_du[i] = du[16*i +: 16];
            exp_u[i]   = u[16*i +: 16];
            exp_du[i]  = du[16*i +: 16];
        end
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Reference: every cell gets u+1 and uL+uR from the previous sweep's values
    task automatic modelSweeps(input int n);
        logic [DW-1:0] old_u[N];
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        for (int s = 0; s < n; s++) begin
            old_u = exp_u;
            for (int i = 0; i < N; i++) begin
                left      = (i == 0) ? 16'd0 : old_u[i-1];
                right     = (i == N - 1) ? 16'd0 : old_u[i+1];
                exp_u[i]  = old_u[i] + 16'd1;
                exp_du[i] = left + right;
            end
        end
    endtask

    task automatic checkRam(input string tag);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s ram_u[%0d]", tag, i), 32'(ram_u[i]), 32'(exp_u[i]));
            checkOutput($sformatf("%s ram_du[%0d]", tag, i), 32'(ram_du[i]), 32'(exp_du[i]));
        end
    endtask

    // Pulse start, then watch the run cycle by cycle until done or budget
    task automatic applyStimulus(input logic [15:0] n, input int poke_at,
                                 output int lat, output int strobes, output int bad);
        strobes = 0;
        bad     = 0;
        start   = 1'b1;
        n_steps = n;
        @(negedge clk);
        start   = 1'b0;
        n_steps = 16'($urandom);
        lat     = 1;
        while (!done && lat < BUDGET) begin
            if (mem_rd_en) strobes++;
            if (mem_wr_en) strobes++;
            if (mem_rd_en && mem_wr_en) bad++;
            if (!busy) bad++;
            if (lat == poke_at) begin
                start   = 1'b1;
                n_steps = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic checkRun(input string tag, input logic [15:0] n, input int lat,
                            input int strobes, input int bad);
        checkOutput({tag, " latency"}, 32'(lat), 32'(1 + int'(n) * SWEEP));
        checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, " step_count"}, 32'(step_count), 32'(n));
        checkOutput({tag, " strobes"}, 32'(strobes), 32'(2 * N * int'(n)));
        checkOutput({tag, " rdwr_overlap_or_busy_gap"}, 32'(bad), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, " step_count_hold"}, 32'(step_count), 32'(n));
    endtask

    initial begin
        int lat;
        int strobes;
        int bad;
        logic [15:0] rn;
        logic [63:0] ru;
        logic [63:0] rdu;

        vecs[0] = '{16'd1, {16'd40, 16'd30, 16'd20, 16'd10}, 64'd0, 32'd15, 16'd1,
                    {16'd41, 16'd31, 16'd21, 16'd11}};
        vecs[1] = '{16'd3, {16'd40, 16'd30, 16'd20, 16'd10}, 64'd0, 32'd43, 16'd3,
                    {16'd43, 16'd33, 16'd23, 16'd13}};
        vecs[2] = '{16'd0, {16'd40, 16'd30, 16'd20, 16'd10}, 64'd0, 32'd1, 16'd0,
                    {16'd40, 16'd30, 16'd20, 16'd10}};
        vecs[3] = '{16'd2, {16'd7, 16'd65535, 16'd0, 16'd100}, {4{16'd5}}, 32'd29, 16'd2,
                    {16'd9, 16'd1, 16'd2, 16'd102}};

        rst_n   = 1'b0;
        start   = 1'b0;
        n_steps = '0;
        load_en = 1'b0;
`ifdef WAVE_SWEEP_ABORT_EN
        abort   = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            load_u[i]  = '0;
            load_du[i] = '0;
        end
        repeat (3) @(negedge clk);

        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset step_count", 32'(step_count), 32'd0);
        checkOutput("reset rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("reset wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("reset addr", 32'(mem_addr), 32'd0);
        checkOutput("reset wu_u", 32'(wu_u), 32'd0);
        checkOutput("reset wu_uR", 32'(wu_uR), 32'd0);
`ifdef WAVE_SWEEP_ABORT_EN
        checkOutput("reset aborted", 32'(aborted), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            loadRam(vecs[v].u_init, vecs[v].du_init);
            applyStimulus(vecs[v].n, -1, lat, strobes, bad);
            checkOutput($sformatf("vec%0d table_latency", v), 32'(lat), vecs[v].exp_lat);
            checkOutput($sformatf("vec%0d table_step_count", v), 32'(step_count), 32'(vecs[v].exp_sc));
            checkRun($sformatf("vec%0d", v), vecs[v].n, lat, strobes, bad);
            modelSweeps(int'(vecs[v].n));
            for (int i = 0; i < N; i++) begin
                checkOutput($sformatf("vec%0d table_u[%0d]", v, i), 32'(ram_u[i]),
                            32'(vecs[v].exp_u[16*i +: 16]));
            end
            checkRam($sformatf("vec%0d", v));
        end

        $display("[TB] start pulsed mid-run must be ignored");
        loadRam({16'd40, 16'd30, 16'd20, 16'd10}, 64'd0);
        applyStimulus(16'd2, 10, lat, strobes, bad);
        checkRun("restart_ignored", 16'd2, lat, strobes, bad);
        modelSweeps(2);
        checkRam("restart_ignored");

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            rn  = 16'($urandom_range(1, 3));
            ru  = {$urandom, $urandom};
            rdu = {$urandom, $urandom};
            loadRam(ru, rdu);
            applyStimulus(rn, int'($urandom_range(2, 20)), lat, strobes, bad);
            checkRun($sformatf("rand%0d", r), rn, lat, strobes, bad);
            modelSweeps(int'(rn));
            checkRam($sformatf("rand%0d", r));
        end

        $display("[TB] reset in the middle of a sweep");
        loadRam({16'd40, 16'd30, 16'd20, 16'd10}, 64'd0);
        start   = 1'b1;
        n_steps = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("midreset wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("midreset addr", 32'(mem_addr), 32'd0);
        checkOutput("midreset step_count", 32'(step_count), 32'd0);
        checkOutput("midreset wu_uL", 32'(wu_uL), 32'd0);
        loadRam({16'd40, 16'd30, 16'd20, 16'd10}, 64'd0);
        applyStimulus(16'd1, -1, lat, strobes, bad);
        checkRun("after_reset", 16'd1, lat, strobes, bad);
        modelSweeps(1);
        checkRam("after_reset");

`ifdef WAVE_SWEEP_ABORT_EN
        $display("[TB] abort during second sweep");
        loadRam({16'd40, 16'd30, 16'd20, 16'd10}, 64'd0);
        start   = 1'b1;
        n_steps = 16'd3;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < BUDGET) begin
            abort = (lat == 20);
            @(negedge clk);
            lat++;
        end
        abort = 1'b0;
        checkOutput("abort latency", 32'(lat), 32'd23);
        checkOutput("abort aborted", 32'(aborted), 32'd1);
        checkOutput("abort step_count", 32'(step_count), 32'd1);
        checkOutput("abort ram_u[0]", 32'(ram_u[0]), 32'd12);
        checkOutput("abort ram_u[1]", 32'(ram_u[1]), 32'd22);
        checkOutput("abort ram_u[2]", 32'(ram_u[2]), 32'd31);
        checkOutput("abort ram_u[3]", 32'(ram_u[3]), 32'd41);
        @(negedge clk);
        loadRam({16'd40, 16'd30, 16'd20, 16'd10}, 64'd0);
        applyStimulus(16'd1, -1, lat, strobes, bad);
        checkOutput("post_abort aborted", 32'(aborted), 32'd0);
        checkRun("post_abort", 16'd1, lat, strobes, bad);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
